// File: rtl/filter_window_feeder_if.sv
// Pixel-in / window-out handshake bundle between the frame fetch path, the
// window feeder and the FilterMac. master = feeder side, slave = environment side.
interface filter_window_feeder_if;
  logic [7:0]      in_pixel;
  logic            in_valid;
  logic            in_sof;
  logic            in_ready;
  logic [8:0][7:0] window;
  logic            out_valid;
  logic            out_ready;
  logic            frame_done;

  modport master (
    input  in_pixel, in_valid, in_sof, out_ready,
    output in_ready, window, out_valid, frame_done
  );

  modport slave (
    output in_pixel, in_valid, in_sof, out_ready,
    input  in_ready, window, out_valid, frame_done
  );
endinterface

// File: rtl/filter_window_feeder.sv
// Raster pixel stream -> 3x3 window feeder with two line buffers.
// Optional FEEDER_PERF_CNT_EN adds stall_cnt / win_cnt performance counters.
module filter_window_feeder #(
  parameter int LINE_W = 640,
  parameter int LINE_H = 480
) (
  input  logic                   clk,
  input  logic                   rst,
  filter_window_feeder_if.master bus
`ifdef FEEDER_PERF_CNT_EN
  ,
  output logic [31:0]            stall_cnt,
  output logic [31:0]            win_cnt
`endif
);
  localparam int CW = $clog2(LINE_W);
  localparam int RW = $clog2(LINE_H);

  logic [CW-1:0]   col_reg, col_cur;
  logic [RW-1:0]   row_reg, row_cur;
  logic [8:0][7:0] sr_reg, sr_next;
  logic [8:0][7:0] window_reg;
  logic            out_valid_reg;
  logic            frame_done_reg;
  logic [7:0]      lb0_mem [LINE_W];
  logic [7:0]      lb1_mem [LINE_W];
  logic [7:0]      new_col [3];
  logic            accept, emit, last_col, last_row;

  assign bus.in_ready   = !out_valid_reg || bus.out_ready;
  assign bus.window     = window_reg;
  assign bus.out_valid  = out_valid_reg;
  assign bus.frame_done = frame_done_reg;

  assign accept = bus.in_valid && bus.in_ready;

  // An accepted start-of-frame restarts the raster position before the pixel is used.
  assign col_cur  = (bus.in_sof) ? '0 : col_reg;
  assign row_cur  = (bus.in_sof) ? '0 : row_reg;
  assign last_col = (col_cur == CW'(LINE_W - 1));
  assign last_row = (row_cur == RW'(LINE_H - 1));
  assign emit     = accept && (row_cur >= RW'(2)) && (col_cur >= CW'(2));

  assign new_col[0] = lb1_mem[col_cur];
  assign new_col[1] = lb0_mem[col_cur];
  assign new_col[2] = bus.in_pixel;

  // Each window row shifts left by one and takes the new column's pixel on the right.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_shift_row
      assign sr_next[3*gi+0] = sr_reg[3*gi+1];
      assign sr_next[3*gi+1] = sr_reg[3*gi+2];
      assign sr_next[3*gi+2] = new_col[gi];
    end
  endgenerate

  // Line buffers: contents need no reset, read and write share the column address.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1_mem[col_cur] <= new_col[1];
      lb0_mem[col_cur] <= bus.in_pixel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_reg        <= '0;
      row_reg        <= '0;
      sr_reg         <= '0;
      window_reg     <= '0;
      out_valid_reg  <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= accept && last_row && last_col;
      if (accept) begin
        sr_reg <= sr_next;
        if (last_col) begin
          col_reg <= '0;
          row_reg <= last_row ? '0 : row_cur + RW'(1);
        end else begin
          col_reg <= col_cur + CW'(1);
          row_reg <= row_cur;
        end
      end
      if (emit) begin
        window_reg    <= sr_next;
        out_valid_reg <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

`ifdef FEEDER_PERF_CNT_EN
  logic sof_accept;
  assign sof_accept = accept && bus.in_sof;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      win_cnt   <= '0;
    end else if (sof_accept) begin
      stall_cnt <= '0;
      win_cnt   <= '0;
    end else begin
      if (out_valid_reg && !bus.out_ready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 32'd1;
      if (out_valid_reg && bus.out_ready && (win_cnt != '1))
        win_cnt <= win_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_filter_window_feeder.sv
// Self-checking bench for filter_window_feeder on a 4x4 frame: a full-image
// reference model feeds a window scoreboard, plus fixed-window and timing checks.
module tb_filter_window_feeder;
  localparam int W = 4;
  localparam int H = 4;

  typedef struct {
    logic [7:0] pix;
    logic       sof;
    logic       exp_fd;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  filter_window_feeder_if bus();

`ifdef FEEDER_PERF_CNT_EN
  logic [31:0] stall_cnt, win_cnt;
`endif

  filter_window_feeder #(.LINE_W(W), .LINE_H(H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FEEDER_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt),
    .win_cnt   (win_cnt)
`endif
  );

  int          pass_cnt = 0;
  int          chk_cnt  = 0;
  int          m_row = 0, m_col = 0;
  int          fd_seen = 0, fd_exp = 0;
  logic [7:0]  img [H][W];
  logic [71:0] sb_q [$];
  logic [71:0] got_q [$];

  function automatic void chk(string nm, logic [71:0] got, logic [71:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endfunction

  // Window whose top-left pixel is base+tl in a raster of width 4 starting at base.
  function automatic logic [71:0] win(int base, int tl);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[(3*r+c)*8 +: 8] = 8'(base + tl + 4*r + c);
    return w;
  endfunction

  function automatic void model_accept(logic [7:0] p, logic sof);
    logic [71:0] w;
    if (sof) begin
      m_row = 0;
      m_col = 0;
    end
    img[m_row][m_col] = p;
    if (m_row >= 2 && m_col >= 2) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          w[(3*r+c)*8 +: 8] = img[m_row-2+r][m_col-2+c];
      sb_q.push_back(w);
    end
    if (m_col == W-1) begin
      m_col = 0;
      if (m_row == H-1) begin
        m_row = 0;
        fd_exp++;
      end else m_row++;
    end else m_col++;
  endfunction

  // Called at a negedge; returns at the negedge after the pixel is accepted.
  task automatic send(input logic [7:0] p, input logic sof);
    bit   done;
    logic rdy;
    int   guard;
    done  = 0;
    guard = 0;
    bus.in_pixel = p;
    bus.in_valid = 1'b1;
    bus.in_sof   = sof;
    while (!done) begin
      #1;
      rdy = bus.in_ready;
      @(posedge clk);
      if (rdy) begin
        model_accept(p, sof);
        done = 1;
      end
      @(negedge clk);
      guard++;
      if (!done && guard > 200) begin
        chk("accept_timeout", 72'd0, 72'd1);
        done = 1;
      end
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic send_frame(input int base);
    for (int i = 0; i < W*H; i++) send(8'(base + i), i == 0);
  endtask

  task automatic drain();
    idle();
    bus.out_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 72'(sb_q.size()), 72'd0);
  endtask

  // Scoreboard monitor: samples after the inputs settle, before the next posedge.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) chk("unexpected_window", bus.window, 72'd0);
        else begin
          chk("window", bus.window, sb_q.pop_front());
          got_q.push_back(bus.window);
        end
      end
      if (bus.frame_done) fd_seen++;
    end
  end

  initial begin
    vec_t        vecs [16];
    int          tl_tab [4];
    int          fd0;
    logic [71:0] held;
    int          g;

    for (int i = 0; i < 16; i++) begin
      vecs[i].pix    = 8'(i);
      vecs[i].sof    = (i == 0);
      vecs[i].exp_fd = (i == 15);
    end
    tl_tab = '{0, 1, 4, 5};

    rst = 1'b1;
    bus.in_pixel  = '0;
    bus.in_valid  = 1'b0;
    bus.in_sof    = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("reset_out_valid", 72'(bus.out_valid), 72'd0);
    chk("reset_window", bus.window, 72'd0);
    chk("reset_frame_done", 72'(bus.frame_done), 72'd0);
    chk("reset_in_ready", 72'(bus.in_ready), 72'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Case 1: full frame, table-driven, frame_done timing per pixel
    got_q.delete();
    fd0 = fd_seen;
    for (int i = 0; i < 16; i++) begin
      send(vecs[i].pix, vecs[i].sof);
      chk($sformatf("frame_done_px%0d", i), 72'(bus.frame_done), 72'(vecs[i].exp_fd));
    end
    drain();
    chk("c1_win_count", 72'(got_q.size()), 72'd4);
    for (int k = 0; k < 4 && k < got_q.size(); k++)
      chk($sformatf("c1_win%0d", k), got_q[k], win(0, tl_tab[k]));
    chk("c1_fd_pulses", 72'(fd_seen - fd0), 72'd1);

    // Case 2: 5 cycles of backpressure after the first window
    got_q.delete();
    bus.out_ready = 1'b0;
    fork
      begin
        send_frame(0);
        idle();
      end
      begin
        g = 0;
        while (!bus.out_valid && g < 100) begin
          @(negedge clk);
          g++;
        end
        chk("c2_first_valid", 72'(bus.out_valid), 72'd1);
        held = bus.window;
        chk("c2_first_window", held, win(0, 0));
        for (int s = 0; s < 5; s++) begin
          chk($sformatf("c2_in_ready_stall%0d", s), 72'(bus.in_ready), 72'd0);
          chk($sformatf("c2_window_hold%0d", s), bus.window, held);
          @(negedge clk);
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk("c2_win_count", 72'(got_q.size()), 72'd4);
    for (int k = 1; k < 4 && k < got_q.size(); k++)
      chk($sformatf("c2_win%0d", k), got_q[k], win(0, tl_tab[k]));
`ifdef FEEDER_PERF_CNT_EN
    chk("c6_stall_cnt", 72'(stall_cnt), 72'd5);
    chk("c6_win_cnt", 72'(win_cnt), 72'd4);
`endif

    // Case 3: asynchronous reset after pixel 9, then a clean frame
    for (int i = 0; i < 10; i++) send(8'(i), i == 0);
    rst = 1'b1;
    #1;
    chk("c3_rst_out_valid", 72'(bus.out_valid), 72'd0);
    chk("c3_rst_window", bus.window, 72'd0);
    sb_q.delete();
    m_row = 0;
    m_col = 0;
    idle();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    got_q.delete();
    fd0 = fd_seen;
    send_frame(0);
    drain();
    chk("c3_win_count", 72'(got_q.size()), 72'd4);
    for (int k = 0; k < 4 && k < got_q.size(); k++)
      chk($sformatf("c3_win%0d", k), got_q[k], win(0, tl_tab[k]));
    chk("c3_fd_pulses", 72'(fd_seen - fd0), 72'd1);

    // Case 4: partial frame then mid-frame resync
    got_q.delete();
    fd0 = fd_seen;
    for (int i = 0; i < 7; i++) send(8'(i), i == 0);
    send_frame(100);
    drain();
    chk("c4_fd_pulses", 72'(fd_seen - fd0), 72'd1);
    chk("c4_win_count", 72'(got_q.size()), 72'd4);
    if (got_q.size() > 0) chk("c4_first_win", got_q[0], win(100, 0));

    // Case 5: back-to-back frames without an idle cycle
    got_q.delete();
    fd0 = fd_seen;
    send_frame(0);
    send_frame(200);
    drain();
    chk("c5_fd_pulses", 72'(fd_seen - fd0), 72'd2);
    chk("c5_win_count", 72'(got_q.size()), 72'd8);
    if (got_q.size() == 8) begin
      chk("c5_f2_win0", got_q[4], win(200, 0));
      chk("c5_f2_win3", got_q[7], win(200, 5));
    end
    chk("model_fd_total", 72'(fd_seen), 72'(fd_exp));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
